// File: rtl/RS5_pkg.sv
// Shared types for the RS5 coprocessor plugins.
//   plugin_op_e    : operation selector carried on the 2-bit op port
//   plugin_state_e : control FSM states of plugin_arith_unit
package RS5_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_MUL   = 2'b10,
    OP_MULHU = 2'b11
  } plugin_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXECUTE,
    S_FINISH
  } plugin_state_e;

endpackage

// File: rtl/plugin_seq_mul.sv
// Iterative radix-2 unsigned shift-add multiplier, sequenced by the parent FSM.
//   clk, reset_n : clock, asynchronous active-low reset
//   init         : load multiplicand=a, multiplier=b, clear accumulator
//   step         : perform one shift-add iteration
//   a, b         : DATA_WIDTH operands
//   product      : {acc, multiplier}; full 2W product after DATA_WIDTH steps
module plugin_seq_mul #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      init,
  input  logic                      step,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [2*DATA_WIDTH-1:0]   product
);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH:0]   sum;

  always_comb begin
    sum = {1'b0, acc};
    if (mplier[0]) sum = {1'b0, acc} + {1'b0, mcand};
  end

  // The low product bits shift into the multiplier register as it is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
    end else if (init) begin
      acc    <= '0;
      mplier <= b;
      mcand  <= a;
    end else if (step) begin
      acc    <= sum[DATA_WIDTH:1];
      mplier <= {sum[0], mplier[DATA_WIDTH-1:1]};
    end
  end

  assign product = {acc, mplier};

endmodule

// File: rtl/plugin_arith_unit.sv
// RS5 arithmetic coprocessor plugin: ADD, SUB, MUL (low half), MULHU.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : request, accepted only in IDLE
//   flush                 : abort an operation in LOAD/EXECUTE
//   op                    : 00 ADD, 01 SUB, 10 MUL, 11 MULHU
//   operand_a, operand_b  : operands
//   result, carry,
//   overflow, zero        : last completed result and flags
//   busy                  : operation in flight
//   done                  : one-cycle completion pulse
module plugin_arith_unit
  import RS5_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int EXTRA_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int MSB   = DATA_WIDTH - 1;

  plugin_state_e state, state_n;
  plugin_op_e    op_q;

  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   res_sh;
  logic                    carry_sh, ovf_sh;
  logic                    is_mul, is_sub;
  logic                    mul_init, mul_step;
  logic [2*DATA_WIDTH-1:0] product;

  logic [DATA_WIDTH-1:0]   addend;
  logic [DATA_WIDTH:0]     sum_ext;
  logic [DATA_WIDTH-1:0]   fin_res;
  logic                    fin_carry, fin_ovf;

  assign is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);
  assign is_sub = (op_q == OP_SUB);

  plugin_seq_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (mul_init),
    .step    (mul_step),
    .a       (a_q),
    .b       (b_q),
    .product (product)
  );

  // SUB is a + ~b + 1; overflow when both addends share a sign the sum lacks.
  always_comb begin
    addend  = is_sub ? ~b_q : b_q;
    sum_ext = {1'b0, a_q} + {1'b0, addend} + (DATA_WIDTH+1)'(is_sub);
  end

  always_comb begin
    fin_res   = res_sh;
    fin_carry = carry_sh;
    fin_ovf   = ovf_sh;
    if (op_q == OP_MUL) begin
      fin_res   = product[DATA_WIDTH-1:0];
      fin_carry = 1'b0;
      fin_ovf   = |product[2*DATA_WIDTH-1:DATA_WIDTH];
    end else if (op_q == OP_MULHU) begin
      fin_res   = product[2*DATA_WIDTH-1:DATA_WIDTH];
      fin_carry = 1'b0;
      fin_ovf   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    mul_init = 1'b0;
    mul_step = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !flush) state_n = S_LOAD;
      end
      S_LOAD: begin
        if (flush) begin
          state_n = S_IDLE;
        end else begin
          state_n  = S_EXECUTE;
          mul_init = is_mul;
        end
      end
      S_EXECUTE: begin
        if (flush)           state_n = S_IDLE;
        else if (cnt == '0)  state_n = S_FINISH;
        else                 mul_step = is_mul;
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      res_sh   <= '0;
      carry_sh <= 1'b0;
      ovf_sh   <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !flush) begin
            op_q <= plugin_op_e'(op);
            a_q  <= operand_a;
            b_q  <= operand_b;
            busy <= 1'b1;
          end
        end
        S_LOAD: begin
          if (flush) begin
            busy <= 1'b0;
          end else if (is_mul) begin
            cnt <= CNT_W'(DATA_WIDTH);
          end else begin
            res_sh   <= sum_ext[DATA_WIDTH-1:0];
            carry_sh <= sum_ext[DATA_WIDTH] ^ is_sub;
            ovf_sh   <= (a_q[MSB] == addend[MSB]) && (sum_ext[MSB] != a_q[MSB]);
            cnt      <= CNT_W'(EXTRA_CYCLES);
          end
        end
        S_EXECUTE: begin
          if (flush)             busy <= 1'b0;
          else if (cnt != '0)    cnt  <= cnt - CNT_W'(1);
        end
        S_FINISH: begin
          result   <= fin_res;
          carry    <= fin_carry;
          overflow <= fin_ovf;
          zero     <= (fin_res == '0);
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plugin_arith_unit.sv
// Self-checking bench for plugin_arith_unit (W=32, EXTRA_CYCLES=0 and 3).
module tb_plugin_arith_unit;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, flush;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [31:0] result;
  logic        carry, overflow, zero, busy, done;

  logic        start2;
  logic [1:0]  op2;
  logic [31:0] a2, b2;
  logic [31:0] result2;
  logic        carry2, overflow2, zero2, busy2, done2;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  plugin_arith_unit #(.DATA_WIDTH(32), .EXTRA_CYCLES(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op_i),
    .operand_a(a_i), .operand_b(b_i), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero), .busy(busy), .done(done)
  );

  plugin_arith_unit #(.DATA_WIDTH(32), .EXTRA_CYCLES(3)) dut_x3 (
    .clk(clk), .reset_n(reset_n), .start(start2), .flush(1'b0), .op(op2),
    .operand_a(a2), .operand_b(b2), .result(result2), .carry(carry2),
    .overflow(overflow2), .zero(zero2), .busy(busy2), .done(done2)
  );

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    logic [63:0] p;
    longint      sr;
    e.c = 1'b0; e.o = 1'b0; e.res = '0;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0]; e.c = s[32];
        sr = longint'($signed(a)) + longint'($signed(b));
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b01: begin
        s = {1'b0, a} - {1'b0, b};
        e.res = s[31:0]; e.c = s[32];
        sr = longint'($signed(a)) - longint'($signed(b));
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b10: begin e.res = p[31:0];  e.o = (p[63:32] != 0); end
      default: e.res = p[63:32];
    endcase
    e.z   = (e.res == 0);
    e.lat = o[1] ? 36 : 4;
    return e;
  endfunction

  // Start an operation; optionally record its expectation and/or skip the edge wait.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input bit immediate);
    if (push) sb.push_back(model(o, a, b));
    if (!immediate) @(negedge clk);
    op_i = o; a_i = a; b_i = b; start = 1'b1;
  endtask

  // Count cycles to done; busy must be high and result stable until then.
  task automatic wait_done(input int repulse_at, output int lat, output bit busy_ok, output bit hold_ok);
    logic [31:0] prev;
    prev = result; lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (lat == repulse_at) begin
        start = 1'b1; a_i = 32'h0BAD_0BAD; b_i = 32'h1111_2222; op_i = 2'b01;
      end
      if (!done) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (result !== prev) hold_ok = 1'b0;
      end else if (busy !== 1'b0) busy_ok = 1'b0;
    end while (!done && lat < 200);
    start = 1'b0;
  endtask

  // Scoreboard: pop the oldest expectation on a completion and compare.
  task automatic score(input string name, input int lat, input bit busy_ok, input bit hold_ok);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s: completion with empty scoreboard", name);
      return;
    end
    passed++;
    e = sb.pop_front();
    checks++; if (lat !== e.lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat); else passed++;
    checks++; if (result !== e.res) $display("FAIL %s result: got %h expected %h", name, result, e.res); else passed++;
    checks++; if (carry !== e.c) $display("FAIL %s carry: got %b expected %b", name, carry, e.c); else passed++;
    checks++; if (overflow !== e.o) $display("FAIL %s overflow: got %b expected %b", name, overflow, e.o); else passed++;
    checks++; if (zero !== e.z) $display("FAIL %s zero: got %b expected %b", name, zero, e.z); else passed++;
    checks++; if (busy_ok !== 1'b1) $display("FAIL %s busy window: got bad expected good", name); else passed++;
    checks++; if (hold_ok !== 1'b1) $display("FAIL %s result hold: got changed expected stable", name); else passed++;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat; bit bo, ho;
    launch(o, a, b, 1'b1, 1'b0);
    wait_done(-1, lat, bo, ho);
    score(name, lat, bo, ho);
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL %s done width: got %b expected 0", name, done); else passed++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    start2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({result, carry, overflow, zero, busy, done} !== 37'd0)
      $display("FAIL reset outputs: got %h expected 0", {result, carry, overflow, zero, busy, done});
    else passed++;
  endtask

  task automatic test_add_sub;
    run_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("add_ovf",  2'b00, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op("sub_borrow", 2'b01, 32'd5, 32'd7);
    run_op("sub_ovf",  2'b01, 32'h8000_0000, 32'd1);
  endtask

  task automatic test_mul;
    run_op("mul_hi",   2'b10, 32'h0001_0000, 32'h0001_0000);
    run_op("mulhu",    2'b11, 32'h0001_0000, 32'h0001_0000);
    run_op("mul_big",  2'b10, 32'hDEAD_BEEF, 32'h1234_5679);
    run_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_start_ignored;
    int lat; bit bo, ho;
    launch(2'b00, 32'd100, 32'd23, 1'b1, 1'b0);
    wait_done(2, lat, bo, ho);
    score("start_ignored", lat, bo, ho);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL start_ignored no queue: got busy %b expected 0", busy); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat; bit bo, ho;
    launch(2'b00, 32'd10, 32'd20, 1'b1, 1'b0);
    wait_done(-1, lat, bo, ho);
    score("b2b_first", lat, bo, ho);
    launch(2'b01, 32'd50, 32'd8, 1'b1, 1'b1);
    wait_done(-1, lat, bo, ho);
    score("b2b_second", lat, bo, ho);
  endtask

  task automatic test_flush;
    logic [31:0] prev;
    bit saw_done, changed;
    prev = result;
    launch(2'b10, 32'd3, 32'd5, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL flush busy: got %b expected 0", busy); else passed++;
    saw_done = 1'b0; changed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (result !== prev) changed = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) $display("FAIL flush done: got pulse expected none"); else passed++;
    checks++; if (changed !== 1'b0) $display("FAIL flush result: got changed expected %h", prev); else passed++;
    start = 1'b1; flush = 1'b1; op_i = 2'b00;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL flush_start_idle busy: got %b expected 0", busy); else passed++;
    run_op("mul_after_flush", 2'b10, 32'h0000_1234, 32'h0000_5678);
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    launch(2'b10, 32'h0000_0F0F, 32'h0000_0303, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({result, carry, overflow, zero, busy, done} !== 37'd0)
      $display("FAIL reset_mid outputs: got %h expected 0", {result, carry, overflow, zero, busy, done});
    else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) $display("FAIL reset_mid activity: got busy/done expected idle"); else passed++;
  endtask

  task automatic test_extra_cycles;
    int lat; bit bo;
    @(negedge clk);
    op2 = 2'b00; a2 = 32'd7; b2 = 32'd8; start2 = 1'b1;
    lat = 0; bo = 1'b1;
    do begin
      @(negedge clk);
      start2 = 1'b0;
      lat++;
      if (!done2 && busy2 !== 1'b1) bo = 1'b0;
    end while (!done2 && lat < 200);
    checks++; if (lat !== 7) $display("FAIL x3 latency: got %0d expected 7", lat); else passed++;
    checks++; if (result2 !== 32'd15) $display("FAIL x3 result: got %h expected %h", result2, 32'd15); else passed++;
    checks++; if (bo !== 1'b1) $display("FAIL x3 busy window: got bad expected good"); else passed++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_start_ignored();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_extra_cycles();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/plugin_arith_unit.md
Name: plugin_arith_unit

Overview:
Parametrised successor to the single-function adder coprocessor plugin for RS5. It accepts an operation code and two DATA_WIDTH operands over the same start/busy/done handshake and returns a result plus status flags. Supported operations are ADD, SUB, MUL (low half) and MULHU (unsigned high half). Multiplies run on an iterative shift-add engine; add/sub latency is programmable.

Parameters:
DATA_WIDTH, 32, operand/result width (>=8)
EXTRA_CYCLES, 0, additional EXECUTE cycles for ADD/SUB (0..15)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE
flush  input  1  synchronous abort of an in-flight operation
op  input  2  plugin_op_e: 00 ADD, 01 SUB, 10 MUL, 11 MULHU
operand_a  input  DATA_WIDTH  first operand
operand_b  input  DATA_WIDTH  second operand
result  output  DATA_WIDTH  last completed result
carry  output  1  ADD carry-out / SUB borrow; 0 for MUL/MULHU
overflow  output  1  ADD/SUB signed overflow; MUL: high half nonzero; MULHU: 0
zero  output  1  result == 0
busy  output  1  operation in flight
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_n=0): state IDLE; result, carry, overflow, zero, busy, done all 0; internal operands/counter/product cleared. Reset mid-operation discards the operation with no done.
- States: IDLE, LOAD, EXECUTE, FINISH.
- IDLE: done<=0, busy<=0; if start: latch op, operand_a, operand_b; busy<=1; ->LOAD. Otherwise stay.
- LOAD: ADD/SUB compute full result and flags into shadow registers; cnt<=EXTRA_CYCLES. MUL/MULHU initialise multiplier (acc=0, multiplier=op_b, multiplicand=op_a); cnt<=DATA_WIDTH. ->EXECUTE.
- EXECUTE: if cnt==0 ->FINISH; else cnt<=cnt-1 and, for MUL/MULHU, perform one shift-add step.
- FINISH: copy shadow result/flags to outputs; busy<=0; done<=1; ->IDLE.
- Latency: start sampled at cycle T -> done high during cycle T+4+cnt_load (ADD/SUB with EXTRA_CYCLES=0: T+4; MUL at W=32: T+36). busy is high T+1 through T+3+cnt_load.
- done is high for exactly one cycle. result and flags hold until the next completion and do not change during an operation.
- Back-to-back: start asserted in the cycle done is high is accepted (state is IDLE).
- start while not IDLE is ignored; there is no queuing.
- flush: in LOAD/EXECUTE -> IDLE next cycle, busy<=0, no done, outputs unchanged. flush in IDLE or FINISH has no effect (FINISH still completes). flush together with start in IDLE: start is ignored.
- Arithmetic: all operations are modulo 2^DATA_WIDTH. SUB = a + ~b + 1; carry = NOT carry-out (borrow). Overflow = sign(a) xor-rule on the operand/result signs. MUL/MULHU are unsigned; the 2W product is formed in acc:multiplier.
- zero is evaluated on the final selected result.

Decomposition:
- RS5_pkg: typedef plugin_op_e (2-bit enum); typedef plugin_state_e (IDLE/LOAD/EXECUTE/FINISH).
- Sub-module plugin_seq_mul (iterative radix-2 unsigned multiplier).
  - Parameter: DATA_WIDTH.
  - Ports: clk, reset_n, init, step, a, b, product[2W].
  - Driven by the parent FSM; contains no FSM of its own.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001, start at T -> done at T+4; result 0x00000000, carry 1, zero 1, overflow 0; busy high T+1..T+3.
- SUB 5 - 7 -> result 0xFFFFFFFE, carry 1, overflow 0. SUB 0x80000000 - 1 -> 0x7FFFFFFF, overflow 1.
- MUL 0x00010000 * 0x00010000 -> result 0, overflow 1, zero 1, done at T+36. MULHU on the same operands -> result 0x00000001.
- start re-pulsed with new operands at T+2 during an ADD -> ignored; the original result is returned. start during the done cycle -> second op accepted, done 4 cycles later.
- flush at T+10 during MUL -> busy low at T+11, no done, result retains its prior value. A second MUL then completes correctly.
- reset_n low at T+5 of MUL -> all outputs 0 immediately. EXTRA_CYCLES=3 build: ADD done at T+7.
